// File: rtl/write_full_block.sv
// Write-domain side of a dual-clock FIFO: binary/Gray write pointer, read-pointer
// synchroniser, and registered full / almost-full / occupancy / sticky-overflow flags.
module write_full_block #(
   parameter int addr_size         = 3,
   parameter int almost_full_level = 1
) (
   input  logic                 write_clock_i,
   input  logic                 write_reset_i,
   input  logic                 write_inc_i,
   input  logic                 overflow_clear_i,
   input  logic [addr_size:0]   read_to_write_pointer_i,
   output logic                 write_en_o,
   output logic [addr_size-1:0] write_address_o,
   output logic [addr_size:0]   write_pointer_o,
   output logic                 write_full_o,
   output logic                 write_almost_full_o,
   output logic [addr_size:0]   write_count_o,
   output logic                 write_overflow_o
);

   localparam int PW = addr_size + 1;
   localparam logic [addr_size:0] C_AF_THRESH = PW'((2 ** addr_size) - almost_full_level);
   // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted
   localparam logic [addr_size:0] C_FULL_FLIP = {2'b11, {(addr_size - 1){1'b0}}};

   function automatic logic [addr_size:0] gray_to_bin(input logic [addr_size:0] g);
      logic [addr_size:0] b;
      b[addr_size] = g[addr_size];
      for (int i = addr_size - 1; i >= 0; i--) begin
         b[i] = b[i + 1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [addr_size:0] bin_to_gray(input logic [addr_size:0] b);
      return (b >> 1) ^ b;
   endfunction

   logic [addr_size:0] r_sync1;
   logic [addr_size:0] r_sync2;
   logic [addr_size:0] r_wbin;

   logic               w_write_en;
   logic [addr_size:0] w_rbin;
   logic [addr_size:0] w_wbin_next;
   logic [addr_size:0] w_wgray_next;
   logic [addr_size:0] w_count_next;
   logic               w_full_next;
   logic               w_almost_full_next;

   always_comb begin
      w_write_en         = write_inc_i & ~write_full_o;
      w_rbin             = gray_to_bin(r_sync2);
      w_wbin_next        = r_wbin + {{addr_size{1'b0}}, w_write_en};
      w_wgray_next       = bin_to_gray(w_wbin_next);
      w_count_next       = w_wbin_next - w_rbin;
      w_full_next        = (w_wgray_next == (r_sync2 ^ C_FULL_FLIP));
      w_almost_full_next = (w_count_next >= C_AF_THRESH) | w_full_next;
   end

   assign write_en_o      = w_write_en;
   assign write_address_o = r_wbin[addr_size-1:0];

   always_ff @(posedge write_clock_i) begin
      if (write_reset_i) begin
         r_sync1             <= '0;
         r_sync2             <= '0;
         r_wbin              <= '0;
         write_pointer_o     <= '0;
         write_full_o        <= 1'b0;
         write_almost_full_o <= 1'b0;
         write_count_o       <= '0;
         write_overflow_o    <= 1'b0;
      end else begin
         r_sync1             <= read_to_write_pointer_i;
         r_sync2             <= r_sync1;
         r_wbin              <= w_wbin_next;
         write_pointer_o     <= w_wgray_next;
         write_full_o        <= w_full_next;
         write_almost_full_o <= w_almost_full_next;
         write_count_o       <= w_count_next;
         // A new overflow outranks a simultaneous clear
         if (write_inc_i & write_full_o) begin
            write_overflow_o <= 1'b1;
         end else if (overflow_clear_i) begin
            write_overflow_o <= 1'b0;
         end else begin
            write_overflow_o <= write_overflow_o;
         end
      end
   end

endmodule

// File: tb/tb_write_full_block.sv
// Scoreboard bench for write_full_block: an occupancy-count model predicts every
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_write_full_block;

   logic       clk = 1'b0;
   logic       write_reset_i = 1'b1;
   logic       write_inc_i = 1'b0;
   logic       overflow_clear_i = 1'b0;
   logic [3:0] read_to_write_pointer_i = 4'b0000;
   logic       write_en_o;
   logic [2:0] write_address_o;
   logic [3:0] write_pointer_o;
   logic       write_full_o;
   logic       write_almost_full_o;
   logic [3:0] write_count_o;
   logic       write_overflow_o;

   write_full_block #(.addr_size(3), .almost_full_level(1)) dut (
      .write_clock_i           (clk),
      .write_reset_i           (write_reset_i),
      .write_inc_i             (write_inc_i),
      .overflow_clear_i        (overflow_clear_i),
      .read_to_write_pointer_i (read_to_write_pointer_i),
      .write_en_o              (write_en_o),
      .write_address_o         (write_address_o),
      .write_pointer_o         (write_pointer_o),
      .write_full_o            (write_full_o),
      .write_almost_full_o     (write_almost_full_o),
      .write_count_o           (write_count_o),
      .write_overflow_o        (write_overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int en;
      int addr;
      int ptr;
      int full;
      int af;
      int cnt;
      int ovf;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model: number of accepted writes since reset, read pointer seen 2 edges late
   int   m_tot = 0, m_cnt = 0, m_full = 0, m_af = 0, m_ovf = 0, m_valid = 0;
   int   s1 = 0, s2 = 0;
   int   p_inc = 0, p_clr = 0, p_rst = 0, p_rd = 0;
   int   rd_tot = 0;

   function automatic logic [3:0] to_gray(input int b);
      logic [3:0] v;
      v = b[3:0];
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int seen;
      int acc;
      if (p_rst != 0) begin
         m_tot = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0;
         s1 = 0; s2 = 0; m_valid = 1;
      end else if (m_valid != 0) begin
         seen  = s2;
         acc   = (p_inc != 0 && m_full == 0) ? 1 : 0;
         m_ovf = (p_inc != 0 && m_full != 0) ? 1 : ((p_clr != 0) ? 0 : m_ovf);
         m_tot = m_tot + acc;
         m_cnt = (((m_tot - seen) % 16) + 16) % 16;
         m_full = (m_cnt == 8) ? 1 : 0;
         m_af   = (m_cnt >= 7) ? 1 : 0;
         s2 = s1;
         s1 = p_rd;
      end
   endtask

   task automatic step(input int inc, input int clr, input int rst, input int rd);
      exp_t e;
      write_inc_i             = inc[0];
      overflow_clear_i        = clr[0];
      write_reset_i           = rst[0];
      read_to_write_pointer_i = to_gray(rd);
      if (m_valid != 0) begin
         e.en   = (inc != 0 && m_full == 0) ? 1 : 0;
         e.addr = m_tot % 8;
         e.ptr  = int'(to_gray(m_tot % 16));
         e.full = m_full;
         e.af   = m_af;
         e.cnt  = m_cnt;
         e.ovf  = m_ovf;
         sb.push_back(e);
      end
      p_inc = inc; p_clr = clr; p_rst = rst; p_rd = rd % 16;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   // Monitor: compare the DUT against the oldest expectation away from the active edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("write_en",    int'(write_en_o),          e.en);
            chk("address",     int'(write_address_o),     e.addr);
            chk("pointer",     int'(write_pointer_o),     e.ptr);
            chk("full",        int'(write_full_o),        e.full);
            chk("almost_full", int'(write_almost_full_o), e.af);
            chk("count",       int'(write_count_o),       e.cnt);
            chk("overflow",    int'(write_overflow_o),    e.ovf);
            chk("full_vs_count", int'(write_full_o), (write_count_o == 4'd8) ? 1 : 0);
         end
      end
   end

   initial begin
      int inc;
      // Reset held with a write request; the request must not count afterwards
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("reset_count", int'(write_count_o), 0);
      chk("reset_ptr", int'(write_pointer_o), 0);

      // Fill 8 back-to-back
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
      chk("fill_ptr", int'(write_pointer_o), 12);
      chk("fill_full", int'(write_full_o), 1);
      chk("fill_count", int'(write_count_o), 8);

      // Overflow while full, clear, then clear colliding with an overflow
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      chk("ovf_ptr", int'(write_pointer_o), 12);
      chk("ovf_set", int'(write_overflow_o), 1);
      step(0, 1, 0, 0);
      chk("ovf_clear", int'(write_overflow_o), 0);
      step(1, 1, 0, 0);
      chk("ovf_set_wins", int'(write_overflow_o), 1);
      step(0, 0, 0, 0);

      // Drain: read pointer jumps to binary 3
      step(0, 0, 0, 3);
      step(0, 0, 0, 3);
      chk("drain_full_lingers", int'(write_full_o), 1);
      step(0, 0, 0, 3);
      chk("drain_full", int'(write_full_o), 0);
      chk("drain_af", int'(write_almost_full_o), 0);
      chk("drain_count", int'(write_count_o), 5);

      // Wrap: both pointers at binary 8, then 8 more writes
      step(0, 0, 1, 0);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 8);
      chk("wrap_empty", int'(write_count_o), 0);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 8);
      chk("wrap_ptr", int'(write_pointer_o), 0);
      chk("wrap_full", int'(write_full_o), 1);
      chk("wrap_count", int'(write_count_o), 8);

      // Random traffic with a reader that never passes the writer
      step(0, 0, 1, 0);
      rd_tot = 0;
      for (int c = 0; c < 10000; c++) begin
         inc = ($urandom_range(0, 99) < 55) ? 1 : 0;
         if (rd_tot < m_tot && $urandom_range(0, 1) == 1) rd_tot++;
         step(inc, ($urandom_range(0, 31) == 0) ? 1 : 0, 0, rd_tot % 16);
      end

      for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_scoreboard: %0d left expected 0", sb.size());
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
